// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: framer states and frame geometry.
package ps2_pkg;

  localparam int unsigned PS2_DATA_BITS = 8;
  localparam int unsigned PS2_FRAME_W   = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer followed by a consecutive-sample glitch filter.
// All flops reset high to match the idle-high PS/2 bus.
module ps2_sync_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic filt
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // cnt tracks how long s2 has disagreed with filt; a flip needs FILTER_LEN samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      filt <= 1'b1;
      cnt  <= '0;
    end else begin
      s1 <= line;
      s2 <= s1;
      if (s2 == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_rx_framer.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, parity, stop.
// Parity is passed through unchecked in scan_code_p[8].
module ps2_rx_framer
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  output logic [PS2_FRAME_W-1:0] scan_code_p,
  output logic                   valid,
  output logic                   frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BW = $clog2(PS2_DATA_BITS);

  logic                     clk_f;
  logic                     data_f;
  logic                     clk_prev;
  logic                     fall;
  ps2_state_e               state;
  logic [BW-1:0]            bit_cnt;
  logic [PS2_DATA_BITS-1:0] shift;
  logic                     parity_q;
  logic [TW-1:0]            to_cnt;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .line  (ps2_clk),
    .filt  (clk_f)
  );

  ps2_sync_filter #(.FILTER_LEN(1)) u_data_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .line  (ps2_data),
    .filt  (data_f)
  );

  assign fall = clk_prev & ~clk_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev    <= 1'b1;
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      parity_q    <= 1'b0;
      to_cnt      <= '0;
      scan_code_p <= '0;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      clk_prev  <= clk_f;
      valid     <= 1'b0;
      frame_err <= 1'b0;

      // Saturating inactivity counter; only meaningful while a frame is open
      if (state == IDLE || fall) begin
        to_cnt <= '0;
      end else if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
        to_cnt <= to_cnt + TW'(1);
      end

      if (fall) begin
        case (state)
          IDLE: begin
            if (!data_f) begin
              state   <= DATA;
              bit_cnt <= '0;
              shift   <= '0;
            end
          end
          DATA: begin
            shift <= {data_f, shift[PS2_DATA_BITS-1:1]};
            if (bit_cnt == BW'(PS2_DATA_BITS - 1)) begin
              state <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
          PARITY: begin
            parity_q <= data_f;
            state    <= STOP;
          end
          STOP: begin
            if (data_f) begin
              scan_code_p <= {parity_q, shift};
              valid       <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state   <= IDLE;
            bit_cnt <= '0;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && to_cnt == TW'(TIMEOUT_CYCLES)) begin
        state   <= IDLE;
        bit_cnt <= '0;
        shift   <= '0;
    end
    end
  end

endmodule

// File: tb/tb_ps2_rx_framer.sv
// Self-checking bench for ps2_rx_framer: table-driven frames plus timeout,
// glitch and mid-frame reset sequences, checked through a scoreboard queue.
module tb_ps2_rx_framer;

  localparam int unsigned FL  = 4;
  localparam int unsigned TO  = 200;
  localparam int unsigned H   = 8;
  localparam int unsigned LAT = FL + 3;

  typedef struct {
    logic       err;
    logic [8:0] code;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_err;
    logic [8:0] exp_code;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [8:0] scan_code_p;
  logic       valid;
  logic       frame_err;

  int   cyc = 0;
  int   stop_cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t vecs[6];

  ps2_rx_framer #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .scan_code_p (scan_code_p),
    .valid       (valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor, sampled on the falling clock edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && frame_err) check("valid_and_err", 9'h1, 9'h0);
      if (valid || frame_err) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {7'd0, valid, frame_err}, 9'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_kind", {8'd0, frame_err}, {8'd0, e.err});
          check("scan_code", scan_code_p, e.code);
          check("latency", 9'(cyc - stop_cyc), 9'(LAT));
        end
      end
    end
  end

  task automatic glitch();
    ps2_clk = 1'b0;
    repeat (FL - 2) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bit(input logic b, input logic is_stop);
    @(negedge clk);
    ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    if (is_stop) stop_cyc = cyc;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int glitch_after);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      send_bit(bits[i], i == 10);
      if (i == glitch_after) begin
        repeat (3) @(negedge clk);
        glitch();
      end
    end
    ps2_data = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain", 9'(sb.size()), 9'h0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 9'h01C};
    vecs[1] = '{8'hF0, 1'b1, 1'b1, 1'b0, 9'h1F0};
    vecs[2] = '{8'h1C, 1'b0, 1'b1, 1'b0, 9'h01C};
    vecs[3] = '{8'h21, 1'b1, 1'b0, 1'b1, 9'h01C};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 9'h0FF};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 9'h100};

    repeat (3) @(negedge clk);
    check("rst_valid", {8'd0, valid}, 9'h0);
    check("rst_err", {8'd0, frame_err}, 9'h0);
    check("rst_code", scan_code_p, 9'h000);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      sb.push_back('{vecs[i].exp_err, vecs[i].exp_code});
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, -1);
      drain();
      check("hold_code", scan_code_p, vecs[i].exp_code);
    end

    // Partial frame (start + 5 bits of 0x23) then bus silence past the timeout
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      logic [7:0] b23;
      b23 = 8'h23;
      send_bit(b23[i], 1'b0);
    end
    repeat (TO + 10) @(negedge clk);
    check("timeout_hold", scan_code_p, 9'h100);
    sb.push_back('{1'b0, 9'h032});
    send_frame(8'h32, 1'b0, 1'b1, -1);
    drain();

    // Short ps2_clk glitches in IDLE and between data bits
    glitch();
    repeat (20) @(negedge clk);
    sb.push_back('{1'b0, 9'h01C});
    send_frame(8'h1C, 1'b0, 1'b1, 3);
    drain();

    // Reset after the 4th data bit, then a clean frame
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b32;
      b32 = 8'h32;
      send_bit(b32[i], 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_valid", {8'd0, valid}, 9'h0);
    check("midrst_err", {8'd0, frame_err}, 9'h0);
    check("midrst_code", scan_code_p, 9'h000);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    sb.push_back('{1'b0, 9'h032});
    send_frame(8'h32, 1'b0, 1'b1, -1);
    drain();
    check("final_code", scan_code_p, 9'h032);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
